// File: rtl/game_state_ctrl.sv
// Game state controller: debounced start/pause/speed buttons drive a WAIT/RUN/PAUSE/END_GAME FSM.
// Optional macro SPEED_RAMP_EN steps game_speed up every RAMP_MOVES accepted moves while running.
module game_state_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int END_HOLD_TICKS  = 8,
   parameter int RAMP_MOVES      = 64
) (
   input  logic        system_clk,
   input  logic        reset,
   input  logic        start_btn,
   input  logic        pause_btn,
   input  logic        speed_btn,
   input  logic        body_tick,
   input  logic        collision,
   output logic [1:0]  game_state,
   output logic [1:0]  game_speed,
   output logic        game_restart,
   output logic [15:0] move_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_WAIT  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_END   = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      SPD_NORMAL = 2'b00,
      SPD_FAST   = 2'b01,
      SPD_SLOW   = 2'b10
   } speed_e;

   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HW  = (END_HOLD_TICKS > 1) ? $clog2(END_HOLD_TICKS) : 1;
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(END_HOLD_TICKS - 1);

   if (DEBOUNCE_CYCLES < 1 || END_HOLD_TICKS < 1 || RAMP_MOVES < 1) begin : g_bad_param
      $error("game_state_ctrl: all count parameters must be at least 1");
   end

   function automatic speed_e select_next(input speed_e s);
      case (s)
         SPD_NORMAL: return SPD_FAST;
         SPD_FAST:   return SPD_SLOW;
         default:    return SPD_NORMAL;
      endcase
   endfunction

`ifdef SPEED_RAMP_EN
   localparam int RW = (RAMP_MOVES > 1) ? $clog2(RAMP_MOVES) : 1;
   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_MOVES - 1);

   function automatic speed_e ramp_next(input speed_e s);
      case (s)
         SPD_SLOW:   return SPD_NORMAL;
         default:    return SPD_FAST;
      endcase
   endfunction

   logic [RW-1:0] ramp_cnt_q;
`endif

   // Button path, bit order {speed, pause, start}.
   logic [2:0]     btn_raw;
   logic [2:0]     meta_q, sync_q, deb_q, deb_dly_q;
   logic [DBW-1:0] db_cnt_q [3];
   logic [2:0]     press;

   assign btn_raw = {speed_btn, pause_btn, start_btn};

   // The counter measures how long the synced level has disagreed with the
   // accepted level; any agreement restarts the measurement.
   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         meta_q    <= '0;
         sync_q    <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         meta_q    <= btn_raw;
         sync_q    <= meta_q;
         deb_dly_q <= deb_q;
         for (int i = 0; i < 3; i++) begin
            if (sync_q[i] == deb_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               deb_q[i]    <= sync_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign press = deb_q & ~deb_dly_q;

   logic start_press, pause_press, speed_press;
   assign start_press = press[0];
   assign pause_press = press[1];
   assign speed_press = press[2];

   state_e         state_q;
   speed_e         speed_q;
   logic           restart_q;
   logic [15:0]    move_count_q, move_count_d;
   logic [HW-1:0]  hold_q;
   logic           move_sat;

   assign move_sat     = (move_count_q == 16'hFFFF);
   assign move_count_d = move_sat ? move_count_q : move_count_q + 16'd1;

   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_WAIT;
         speed_q      <= SPD_NORMAL;
         restart_q    <= 1'b0;
         move_count_q <= '0;
         hold_q       <= '0;
`ifdef SPEED_RAMP_EN
         ramp_cnt_q   <= '0;
`endif
      end else begin
         restart_q <= 1'b0;
         case (state_q)
            ST_WAIT: begin
               if (start_press) begin
                  state_q      <= ST_RUN;
                  restart_q    <= 1'b1;
                  move_count_q <= '0;
`ifdef SPEED_RAMP_EN
                  ramp_cnt_q   <= '0;
`endif
               end else if (speed_press) begin
                  speed_q <= select_next(speed_q);
               end
            end
            ST_RUN: begin
               if (collision) begin
                  state_q <= ST_END;
                  hold_q  <= '0;
               end else if (pause_press) begin
                  state_q <= ST_PAUSE;
               end else if (body_tick && !move_sat) begin
                  move_count_q <= move_count_d;
`ifdef SPEED_RAMP_EN
                  if (ramp_cnt_q == RAMP_LAST) begin
                     ramp_cnt_q <= '0;
                     speed_q    <= ramp_next(speed_q);
                  end else begin
                     ramp_cnt_q <= ramp_cnt_q + 1'b1;
                  end
`endif
               end
            end
            ST_PAUSE: begin
               if (pause_press || start_press) state_q <= ST_RUN;
            end
            ST_END: begin
               // A start press only returns to WAIT; a second press is needed to play.
               if (start_press) begin
                  state_q <= ST_WAIT;
               end else if (body_tick) begin
                  if (hold_q == HOLD_LAST) state_q <= ST_WAIT;
                  else                     hold_q  <= hold_q + 1'b1;
               end
            end
            default: state_q <= ST_WAIT;
         endcase
      end
   end

   assign game_state   = state_q;
   assign game_speed   = speed_q;
   assign game_restart = restart_q;
   assign move_count   = move_count_q;

endmodule
